mul_add_pipelined: RTL and testbench

- Pipelined radix-2 shift-add multiply-accumulate: computes prod = a*b + c, one new operand set accepted every cycle.
- Inverse companion of the pipelined divider: feeding it quot, d and rem reconstructs the dividend (z = quot*d + rem).
- Used by the C backend hardware for multiply ops and for divider result checking; same latency class as the divider, WIDTH+1 cycles.

---
 rtl/mul_add_pipelined_pkg.sv | 25 ++
 rtl/mul_add_pipelined_mul_stage.sv | 44 ++++
 rtl/mul_add_pipelined.sv | 49 ++++
 tb/tb_mul_add_pipelined.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mul_add_pipelined_pkg.sv
// Shared width constants, stage record and operand extension for the pipelined multiply-add.
// Build option: define MUL_SIGNED_EN for two's-complement operands.
package mul_add_pipelined_pkg;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned PROD_W      = 2 * WIDTH;
    localparam int unsigned MUL_LATENCY = WIDTH + 1;

    typedef struct packed {
        logic [PROD_W-1:0] acc;
        logic [PROD_W-1:0] a;
        logic [WIDTH-1:0]  b;
        logic              valid;
    } stage_t;

    // Widen an operand to product width: sign-extend in the signed build, zero-extend otherwise.
    function automatic logic [PROD_W-1:0] extend(input logic [WIDTH-1:0] x);
`ifdef MUL_SIGNED_EN
        return {{WIDTH{x[WIDTH-1]}}, x};
`else
        return {{WIDTH{1'b0}}, x};
`endif
    endfunction

endpackage

// File: rtl/mul_add_pipelined_mul_stage.sv
// One shift-add step of the multiply-add pipeline; consumes multiplier bit K-1.
// Build option: MUL_SIGNED_EN makes the final step subtract the sign-weighted partial product.
module mul_stage
    import mul_add_pipelined_pkg::*;
#(
    parameter int unsigned K = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  stage_t prev_stage,
    output stage_t stage
);

`ifdef MUL_SIGNED_EN
    localparam bit NEG_STEP = (K == WIDTH);
`else
    localparam bit NEG_STEP = 1'b0;
`endif

    logic [PROD_W-1:0] partial_c;
    logic [PROD_W-1:0] acc_next_c;

    // Partial product for this bit; the top multiplier bit carries negative weight when signed.
    always_comb begin
        partial_c  = '0;
        if (prev_stage.b[K-1]) begin
            partial_c = prev_stage.a << (K - 1);
        end
        acc_next_c = NEG_STEP ? (prev_stage.acc - partial_c)
                              : (prev_stage.acc + partial_c);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage <= '0;
        end else begin
            stage.acc   <= acc_next_c;
            stage.a     <= prev_stage.a;
            stage.b     <= prev_stage.b;
            stage.valid <= prev_stage.valid;
        end
    end

endmodule

// File: rtl/mul_add_pipelined.sv
// Pipelined shift-add multiply-accumulate: prod = a*b + c, WIDTH+1 cycles latency, one op per cycle.
// Build option: MUL_SIGNED_EN selects two's-complement operands; width is set in the package.
module mul_add_pipelined
    import mul_add_pipelined_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [WIDTH-1:0]  c,
    output logic [PROD_W-1:0] prod,
    output logic              out_valid
);

    stage_t pipe [WIDTH+1];

    // Stage 0: capture operands, accumulator seeded with the addend.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe[0] <= '0;
        end else begin
            pipe[0].acc   <= extend(c);
            pipe[0].a     <= extend(a);
            pipe[0].b     <= b;
            pipe[0].valid <= in_valid;
        end
    end

    for (genvar k = 1; k <= WIDTH; k++) begin : g_stage
        mul_stage #(.K(k)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_stage (pipe[k-1]),
            .stage      (pipe[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prod      <= '0;
            out_valid <= 1'b0;
        end else begin
            prod      <= pipe[WIDTH].acc;
            out_valid <= pipe[WIDTH].valid;
        end
    end

endmodule

// File: tb/tb_mul_add_pipelined.sv
// Self-checking bench for mul_add_pipelined: directed and random ops against an arithmetic reference.
module tb_mul_add_pipelined;
    import mul_add_pipelined_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [WIDTH-1:0]  a, b, c;
    logic [PROD_W-1:0] prod;
    logic              out_valid;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    typedef struct {
        int                due;
        logic [PROD_W-1:0] val;
    } exp_t;
    exp_t q[$];

    mul_add_pipelined dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .prod      (prod),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [PROD_W-1:0] ref_mac(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic [WIDTH-1:0] z);
`ifdef MUL_SIGNED_EN
        logic signed [PROD_W-1:0] sx, sy, sz;
        sx = PROD_W'($signed(x));
        sy = PROD_W'($signed(y));
        sz = PROD_W'($signed(z));
        return sx * sy + sz;
`else
        return PROD_W'(x) * PROD_W'(y) + PROD_W'(z);
`endif
    endfunction

    task automatic chk(input string tag, input logic [PROD_W-1:0] obs, input logic [PROD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_cnt, obs, exp);
        end
    endtask

    // Advance one edge and compare outputs with the expected-result schedule.
    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
        if (q.size() > 0 && q[0].due == edge_cnt) begin
            chk("out_valid_hi", PROD_W'(out_valid), PROD_W'(1'b1));
            chk("prod", prod, q[0].val);
            void'(q.pop_front());
        end else begin
            chk("out_valid_lo", PROD_W'(out_valid), PROD_W'(1'b0));
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] z, input logic [PROD_W-1:0] exp);
        exp_t e;
        in_valid = 1'b1;
        a = x;
        b = y;
        c = z;
        e.due = edge_cnt + 1 + int'(MUL_LATENCY);
        e.val = exp;
        q.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (MUL_LATENCY + 2) step();
        chk("queue_empty", PROD_W'(q.size()), PROD_W'(0));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb, rc;
        logic [WIDTH-1:0] ones;
        ones     = '1;
        rst      = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        c = '0;

        // Reset state
        step();
        step();
        chk("reset_prod", prod, '0);
        rst = 1'b1;

        // Single op: exactly one valid pulse after WIDTH+1 edges
        issue(13, 7, 5, PROD_W'(96));
        drain();

`ifdef MUL_SIGNED_EN
        issue(WIDTH'(-3), 5, WIDTH'(-1), PROD_W'(-16));
        issue(ones >> 1 ^ ones, ones >> 1 ^ ones, 0, PROD_W'(1) << (2 * WIDTH - 2));
        issue(ones, ones, ones, '0);
`else
        issue(ones, ones, ones, ~(PROD_W'(ones)));
`endif
        issue(0, 200, 17, PROD_W'(17));
        issue(55, 0, 9, PROD_W'(9));
        issue(142, 7, 6, PROD_W'(1000));
        issue(1234, 5678, 0, PROD_W'(1234 * 5678));
        drain();

        // Back-to-back random ops
        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = WIDTH'($urandom);
            issue(ra, rb, rc, ref_mac(ra, rb, rc));
        end
        drain();

        // Reset mid-flight, operand offered on the reset edge is dropped too
        for (int i = 0; i < 4; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = WIDTH'($urandom);
            issue(ra, rb, rc, ref_mac(ra, rb, rc));
        end
        q.delete();
        rst      = 1'b0;
        in_valid = 1'b1;
        a = 3;
        b = 4;
        c = 5;
        step();
        chk("midreset_prod", prod, '0);
        rst      = 1'b1;
        in_valid = 1'b0;
        ra = WIDTH'($urandom);
        rb = WIDTH'($urandom);
        rc = WIDTH'($urandom);
        issue(ra, rb, rc, ref_mac(ra, rb, rc));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
